// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcode
// classes, opcode constants and the datapath mux select codes.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_ILLEGAL
    } op_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // pc_src: where the next PC comes from
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JALR   = 2'd2;

    // alu_src_a
    localparam logic [1:0] ASRC_PC    = 2'd0;
    localparam logic [1:0] ASRC_RS1   = 2'd1;
    localparam logic [1:0] ASRC_OLDPC = 2'd2;

    // alu_src_b
    localparam logic [1:0] BSRC_RS2  = 2'd0;
    localparam logic [1:0] BSRC_FOUR = 2'd1;
    localparam logic [1:0] BSRC_IMM  = 2'd2;

    // alu_op
    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    // wb_sel
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Control-flow instructions finish (and retire) in EX.
    function automatic logic retires_in_ex(input op_class_e cls);
        return (cls == CL_BRANCH) || (cls == CL_JAL) || (cls == CL_JALR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory-port bundle between the controller (master) and the unified
// instruction/data memory (slave).
//
// Handshake: mem_req is the request valid, mem_ready is the completion.
// A request transfers in any cycle where mem_req and mem_ready are both 1.
// Once raised, mem_req stays high (with mem_we and mem_addr_sel stable)
// until that cycle; mem_ready is meaningless while mem_req is low.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller_opcode_class_decoder.sv
// Pure combinational map from the RV32I major opcode to an instruction class.
// Anything outside the supported subset is classed as illegal.
module multicycle_controller_opcode_class_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class
);

    // Classify the opcode field of IR
    always_comb begin
        op_class = CL_ILLEGAL;
        case (opcode)
            OPC_R:      op_class = CL_R;
            OPC_I:      op_class = CL_I;
            OPC_LOAD:   op_class = CL_LOAD;
            OPC_STORE:  op_class = CL_STORE;
            OPC_BRANCH: op_class = CL_BRANCH;
            OPC_JAL:    op_class = CL_JAL;
            OPC_JALR:   op_class = CL_JALR;
            default:    op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath (IF, ID, EX, MEM, WB).
// Outputs are decoded from the registered state plus the live mem_ready /
// branch_taken inputs, so IR/PC loads happen in the cycle memory completes
// and a branch writes PC in the same EX cycle the compare resolves.
// All strobes are forced low while rstn is low so an in-flight memory
// request is dropped the instant reset asserts.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [6:0]                opcode,
    input  logic                      branch_taken,
    multicycle_controller_if.master   mem,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic [1:0]                pc_src,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [1:0]                alu_op,
    output logic                      reg_write,
    output logic [1:0]                wb_sel,
    output logic                      illegal_instr,
    output logic [DATA_WIDTH-1:0]     instret,
    output logic [2:0]                state
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;
    logic                  illegal_q, illegal_d;
    op_class_e             op_class;

    // Ungated strobes; gated with rstn at the ports
    logic mem_req_c;
    logic ir_write_c;
    logic pc_write_c;
    logic reg_write_c;

    multicycle_controller_opcode_class_decoder u_decoder (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // Next-state, counters and per-state datapath controls
    always_comb begin
        state_d          = state_q;
        instret_d        = instret_q;
        illegal_d        = illegal_q;
        mem_req_c        = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_write_c       = 1'b0;
        pc_write_c       = 1'b0;
        pc_src           = PCSRC_ALU;
        alu_src_a        = ASRC_PC;
        alu_src_b        = BSRC_RS2;
        alu_op           = ALUOP_ADD;
        reg_write_c      = 1'b0;
        wb_sel           = WB_ALUOUT;

        case (state_q)
            S_IF: begin
                // Fetch at PC while the ALU forms PC+4
                mem_req_c = 1'b1;
                alu_src_a = ASRC_PC;
                alu_src_b = BSRC_FOUR;
                alu_op    = ALUOP_ADD;
                if (mem.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    pc_src     = PCSRC_ALU;
                    state_d    = S_ID;
                end
            end

            S_ID: begin
                // Speculative branch/jal target into alu_out
                alu_src_a = ASRC_OLDPC;
                alu_src_b = BSRC_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = S_EX;
            end

            S_EX: begin
                state_d = S_IF;
                case (op_class)
                    CL_R: begin
                        alu_src_a = ASRC_RS1;
                        alu_src_b = BSRC_RS2;
                        alu_op    = ALUOP_FUNCT;
                        state_d   = S_WB;
                    end
                    CL_I: begin
                        alu_src_a = ASRC_RS1;
                        alu_src_b = BSRC_IMM;
                        alu_op    = ALUOP_FUNCT;
                        state_d   = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_a = ASRC_RS1;
                        alu_src_b = BSRC_IMM;
                        alu_op    = ALUOP_ADD;
                        state_d   = S_MEM;
                    end
                    CL_BRANCH: begin
                        alu_src_a  = ASRC_RS1;
                        alu_src_b  = BSRC_RS2;
                        alu_op     = ALUOP_BRANCH;
                        pc_write_c = branch_taken;
                        pc_src     = PCSRC_ALUOUT;
                    end
                    CL_JAL: begin
                        pc_write_c  = 1'b1;
                        pc_src      = PCSRC_ALUOUT;
                        reg_write_c = 1'b1;
                        wb_sel      = WB_PC;
                    end
                    CL_JALR: begin
                        alu_src_a   = ASRC_RS1;
                        alu_src_b   = BSRC_IMM;
                        alu_op      = ALUOP_ADD;
                        pc_write_c  = 1'b1;
                        pc_src      = PCSRC_JALR;
                        reg_write_c = 1'b1;
                        wb_sel      = WB_PC;
                    end
                    default: begin
                        // Unsupported opcode: flag it and carry on as a NOP
                        illegal_d = 1'b1;
                    end
                endcase
                if (retires_in_ex(op_class)) begin
                    instret_d = instret_q + DATA_WIDTH'(1);
                end
            end

            S_MEM: begin
                mem_req_c        = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (op_class == CL_STORE);
                if (mem.mem_ready) begin
                    if (op_class == CL_STORE) begin
                        instret_d = instret_q + DATA_WIDTH'(1);
                        state_d   = S_IF;
                    end else begin
                        state_d   = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write_c = 1'b1;
                wb_sel      = (op_class == CL_LOAD) ? WB_MDR : WB_ALUOUT;
                instret_d   = instret_q + DATA_WIDTH'(1);
                state_d     = S_IF;
            end

            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // State, retired count and sticky illegal flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IF;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem.mem_req   = mem_req_c   & rstn;
    assign ir_write      = ir_write_c  & rstn;
    assign pc_write      = pc_write_c  & rstn;
    assign reg_write     = reg_write_c & rstn;
    assign illegal_instr = illegal_q;
    assign instret       = instret_q;
    assign state         = state_q;

endmodule
